// File: rtl/md6_rx_pkg.sv
// Shared definitions for the MD6 receive loader: FSM encoding, field sizes and
// a per-state byte-count helper.
package md6_rx_pkg;

  // Receive states 0..7 double as done-flag / write-enable indices.
  typedef enum logic [3:0] {
    S_M      = 4'd0,
    S_D      = 4'd1,
    S_K      = 4'd2,
    S_L      = 4'd3,
    S_R      = 4'd4,
    S_KEYLEN = 4'd5,
    S_PAD    = 4'd6,
    S_IDX    = 4'd7,
    S_START  = 4'd8,
    S_WAIT   = 4'd9,
    S_DONE   = 4'd10
  } state_e;

  localparam int unsigned D_BYTES      = 2;
  localparam int unsigned L_BYTES      = 1;
  localparam int unsigned R_BYTES      = 2;
  localparam int unsigned KEYLEN_BYTES = 1;
  localparam int unsigned PAD_BYTES    = 2;
  localparam int unsigned IDX_BYTES    = 1;

  localparam int unsigned D_W      = 8 * D_BYTES;
  localparam int unsigned L_W      = 8 * L_BYTES;
  localparam int unsigned R_W      = 8 * R_BYTES;
  localparam int unsigned KEYLEN_W = 8 * KEYLEN_BYTES;
  localparam int unsigned PAD_W    = 8 * PAD_BYTES;
  localparam int unsigned IDX_W    = 8 * IDX_BYTES;

  // S_DONE counts as S_M: a byte there opens the next frame's message field.
  function automatic int unsigned field_nbytes(input state_e s,
                                               input int unsigned m_bytes,
                                               input int unsigned k_bytes);
    case (s)
      S_M, S_DONE: field_nbytes = m_bytes;
      S_D:         field_nbytes = D_BYTES;
      S_K:         field_nbytes = k_bytes;
      S_L:         field_nbytes = L_BYTES;
      S_R:         field_nbytes = R_BYTES;
      S_KEYLEN:    field_nbytes = KEYLEN_BYTES;
      S_PAD:       field_nbytes = PAD_BYTES;
      S_IDX:       field_nbytes = IDX_BYTES;
      default:     field_nbytes = 1;
    endcase
  endfunction

endpackage

// File: rtl/md6_field_shift.sv
// Byte-indexed field register: byte i of the field is written when the index
// matches, so the first byte received ends up in the least significant lane.
module md6_field_shift #(
  parameter int unsigned NBYTES = 1,
  parameter int unsigned IDXW   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [IDXW-1:0]       i_idx,
  input  logic [7:0]            i_byte,
  output logic [8*NBYTES-1:0]   o_field
);

  logic [NBYTES-1:0][7:0] r_bytes;

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    always_ff @(posedge i_clk) begin
      if (i_reset)
        r_bytes[b] <= 8'h00;
      else if (i_we && (i_idx == IDXW'(b)))
        r_bytes[b] <= i_byte;
    end
  end

  assign o_field = r_bytes;

endmodule

// File: rtl/md6_rx_loader.sv
// Sequences UART bytes into the MD6 frame fields, starts the CF and waits for it.
// Optional inter-byte timeout: define MD6_RX_TIMEOUT_EN.
module md6_rx_loader
  import md6_rx_pkg::*;
#(
  parameter int unsigned M_BYTES        = 32,
  parameter int unsigned K_BYTES        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_cf_done,
  output logic [8*M_BYTES-1:0]  o_M,
  output logic [D_W-1:0]        o_d,
  output logic [8*K_BYTES-1:0]  o_K,
  output logic [L_W-1:0]        o_L,
  output logic [R_W-1:0]        o_r,
  output logic [KEYLEN_W-1:0]   o_keylen,
  output logic [PAD_W-1:0]      o_padding,
  output logic [IDX_W-1:0]      o_index_pad,
  output logic                  o_done_M,
  output logic                  o_done_d,
  output logic                  o_done_K,
  output logic                  o_done_L,
  output logic                  o_done_r,
  output logic                  o_done_keylen,
  output logic                  o_done_padding,
  output logic                  o_done_rx,
  output logic                  o_cf_start,
  output logic                  o_done_md6,
  output logic                  o_overrun
);

  localparam int unsigned MAXB = (M_BYTES > K_BYTES) ? M_BYTES : K_BYTES;
  localparam int unsigned CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_done;       // bit per receive state; bit 7 is done_rx
  logic            r_done_md6;
  logic            r_overrun;
  logic            r_cf_start;

  logic            w_rx_state;
  logic [CW-1:0]   w_idx;
  logic            w_last;
  logic [7:0]      w_we;
  logic            w_timeout;

  assign w_rx_state = (r_state <= S_IDX);
  assign w_idx      = (r_state == S_DONE) ? '0 : r_cnt;
  assign w_last     = (w_idx == CW'(field_nbytes(r_state, M_BYTES, K_BYTES) - 1));

  always_comb begin
    w_we = '0;
    if (i_rx_valid) begin
      if (w_rx_state)
        w_we[r_state[2:0]] = 1'b1;
      else if (r_state == S_DONE)
        w_we[0] = 1'b1;
    end
  end

`ifdef MD6_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_gap;
  logic          r_started;

  // Gap only counts once the frame has begun; completing the frame disarms it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gap     <= '0;
      r_started <= 1'b0;
    end else if (i_rx_valid && (w_rx_state || r_state == S_DONE)) begin
      r_gap     <= '0;
      r_started <= !(r_state == S_IDX && w_last);
    end else if (w_timeout) begin
      r_gap     <= '0;
      r_started <= 1'b0;
    end else if (w_rx_state && r_started) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  assign w_timeout = w_rx_state && r_started && !i_rx_valid &&
                     (r_gap == TW'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: a partial frame waits indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_M;
      r_cnt      <= '0;
      r_done     <= '0;
      r_done_md6 <= 1'b0;
      r_overrun  <= 1'b0;
      r_cf_start <= 1'b0;
    end else begin
      r_cf_start <= 1'b0;
      case (r_state)
        S_M, S_D, S_K, S_L, S_R, S_KEYLEN, S_PAD, S_IDX: begin
          if (i_rx_valid) begin
            if (w_last) begin
              r_cnt                 <= '0;
              r_done[r_state[2:0]]  <= 1'b1;
              r_state               <= state_e'(r_state + 4'd1);
              if (r_state == S_IDX)
                r_cf_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_M;
            r_cnt   <= '0;
            r_done  <= '0;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          if (i_rx_valid)
            r_overrun <= 1'b1;
        end
        S_WAIT: begin
          if (i_rx_valid)
            r_overrun <= 1'b1;
          if (i_cf_done) begin
            r_done_md6 <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_rx_valid) begin
            r_done_md6 <= 1'b0;
            r_overrun  <= 1'b0;
            r_done     <= {7'd0, w_last};
            r_state    <= w_last ? S_D : S_M;
            r_cnt      <= w_last ? '0 : CW'(1);
          end
        end
        default: begin
          r_state <= S_M;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  md6_field_shift #(.NBYTES(M_BYTES), .IDXW(CW)) u_m (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[0]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_M));
  md6_field_shift #(.NBYTES(D_BYTES), .IDXW(CW)) u_d (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[1]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_d));
  md6_field_shift #(.NBYTES(K_BYTES), .IDXW(CW)) u_k (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[2]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_K));
  md6_field_shift #(.NBYTES(L_BYTES), .IDXW(CW)) u_l (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[3]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_L));
  md6_field_shift #(.NBYTES(R_BYTES), .IDXW(CW)) u_r (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[4]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_r));
  md6_field_shift #(.NBYTES(KEYLEN_BYTES), .IDXW(CW)) u_keylen (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[5]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_keylen));
  md6_field_shift #(.NBYTES(PAD_BYTES), .IDXW(CW)) u_pad (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[6]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_padding));
  md6_field_shift #(.NBYTES(IDX_BYTES), .IDXW(CW)) u_idx (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[7]), .i_idx(w_idx),
    .i_byte(i_rx_data), .o_field(o_index_pad));

  assign o_done_M       = r_done[0];
  assign o_done_d       = r_done[1];
  assign o_done_K       = r_done[2];
  assign o_done_L       = r_done[3];
  assign o_done_r       = r_done[4];
  assign o_done_keylen  = r_done[5];
  assign o_done_padding = r_done[6];
  assign o_done_rx      = r_done[7];
  assign o_cf_start     = r_cf_start;
  assign o_done_md6     = r_done_md6;
  assign o_overrun      = r_overrun;

endmodule

// File: doc/md6_rx_loader.md
Name: md6_rx_loader

Overview:
Byte-stream sequencer between the UART receiver and the MD6 compression-function (CF) core. Consumes received bytes in fixed frame order (M, d, K, L, r, keylen, padding, index_pad) and assembles each field into its register. Raises per-field done flags, pulses CF start once the frame is complete, then holds until the CF reports completion. Sits in top between uart_rx and the CF datapath; the TX path reads the digest after done_md6.

Parameters:
M_BYTES, 32, message bytes per frame (M field width = 8*M_BYTES)
K_BYTES, 8, key bytes per frame (K field width = 8*K_BYTES)
TIMEOUT_CYCLES, 2000000, inter-byte gap limit in clk cycles (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  one-cycle strobe, rx_data valid
cf_done  in  1  CF core finished (level or pulse, sampled in S_WAIT)
M  out  8*M_BYTES  message field
d  out  16  digest length
K  out  8*K_BYTES  key field
L  out  8  mode/level
r  out  16  rounds
keylen  out  8  key length
padding  out  16  padding bit count
index_pad  out  8  index pad
done_M, done_d, done_K, done_L, done_r, done_keylen, done_padding  out  1 each  field complete (sticky until new frame)
done_rx  out  1  whole frame received
cf_start  out  1  one-cycle start pulse to CF
done_md6  out  1  CF finished, digest valid
overrun  out  1  sticky: byte arrived while not accepting

Behaviour:
- Reset: all field registers 0, all done flags 0, cf_start 0, done_md6 0, overrun 0, byte counter 0, state S_M. Reset mid-frame discards partial data.
- FSM states: S_M, S_D, S_K, S_L, S_R, S_KEYLEN, S_PAD, S_IDX, S_START, S_WAIT, S_DONE.
- Field byte counts: M=M_BYTES, d=2, K=K_BYTES, L=1, r=2, keylen=1, padding=2, index_pad=1.
- Assembly for M and K: byte i (from 0) lands at bits [8i+7:8i]. So the first received byte is the LSB.
- Assembly for multi-byte numeric fields: little-endian. Example: padding bytes 0xE8,0x0F give 4072.
- Each rx_valid in a receive state writes one byte in the same cycle. The register updates on that edge and the counter increments.
- On the last byte of a field: set that field's done flag on the same edge, clear the counter, advance to the next state.
- Byte counter is wide enough for max(M_BYTES,K_BYTES)-1 and wraps to 0 at each field end.
- S_IDX last byte: set done_rx and go to S_START.
- S_START: cf_start=1 for exactly one cycle, then S_WAIT.
- S_WAIT: cf_done=1 sets done_md6 and moves to S_DONE. cf_done in the same cycle as cf_start is ignored.
- S_DONE: outputs hold. The next rx_valid starts a new frame:
  - clear all done flags, done_md6 and overrun;
  - write that byte as M byte 0 (counter=1);
  - go to S_M.
- rx_valid in S_START or S_WAIT: byte dropped, overrun set, no state change.
- rx_valid is never back-to-back in practice, but consecutive strobes are still each accepted.
- Latency: last index_pad byte to cf_start is 1 cycle.

Optional Feature:
MD6_RX_TIMEOUT_EN:
- Defined:
  - A gap counter runs in receive states once at least one byte of the frame has arrived. It clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES, return to S_M with counter 0 and clear all done flags. Field registers are kept.
  - Timeout does not apply in S_START, S_WAIT or S_DONE.
- Undefined: no gap counter; a partial frame waits indefinitely.

Decomposition:
- Package md6_rx_pkg holds:
  - the state encoding;
  - per-field byte-count constants (D_BYTES=2, L_BYTES=1, R_BYTES=2, KEYLEN_BYTES=1, PAD_BYTES=2, IDX_BYTES=1);
  - field widths.
- One natural sub-module: md6_field_shift, a byte-indexed register writer (byte, index, write enable → field). It is instantiated per field width.

Test Plan:
- Full frame: M "abc"+29 zero bytes, d 0x00,0x01, K 8×0x00, L 0x40, r 0x05,0x00, keylen 0x00, padding 0xE8,0x0F, index 0x00. Required: M[23:0]=0x636261, d=256, L=64, r=5, padding=4072, each done flag rises on its last byte, cf_start one pulse one cycle after the index byte.
- cf_done 50 cycles after cf_start → done_md6=1 on the following edge, outputs stable.
- Byte injected during S_WAIT → overrun=1, frame fields unchanged, done_md6 still rises on cf_done.
- Reset asserted after 10 M bytes, then a full frame → fields match the second frame only, no stale done flags.
- New frame first byte 0x11 in S_DONE → all done flags and done_md6 clear, M[7:0]=0x11.
- With MD6_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 3 bytes then idle 100 cycles → state S_M, counter 0. The next byte lands at M[7:0].
